// File: rtl/frame_pkg.sv
// Shared framing constants and aligner state type.
// The mapper's FAS insertion uses the same FAS bytes and frame geometry.
package frame_pkg;

    localparam int         ROW_NUM     = 4;
    localparam int         COL_NUM     = 1024;
    localparam logic [7:0] FAS_B0      = 8'hF6;
    localparam logic [7:0] FAS_B1      = 8'h28;
    localparam int         PRESYNC_NUM = 2;
    localparam int         LOSS_NUM    = 3;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PRESYNC = 2'd1,
        SYNC    = 2'd2
    } align_state_t;

    // True when the byte pair {prev, cur} equals the FAS pair {b0, b1}.
    function automatic logic fas_pair_match(
        input logic [7:0] prev,
        input logic [7:0] cur,
        input logic [7:0] b0,
        input logic [7:0] b1
    );
        return (prev == b0) && (cur == b1);
    endfunction

endpackage

// File: rtl/frame_aligner_fas_detect.sv
// fas_detect: two-entry byte delay line advanced on valid beats, with a
// combinational strobe when the newest stored byte and the incoming byte
// form the FAS pair. o_leave is the byte pushed out by the current beat.
module fas_detect #(
    parameter logic [7:0] B0 = frame_pkg::FAS_B0,
    parameter logic [7:0] B1 = frame_pkg::FAS_B1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic [7:0] o_leave,
    output logic       o_match
);
    import frame_pkg::*;

    logic [7:0] line0_q;
    logic [7:0] line1_q;
    logic [7:0] line0_d;
    logic [7:0] line1_d;

    // Shift the line only on valid beats so gaps freeze the comparison window.
    always_comb begin
        line0_d = line0_q;
        line1_d = line1_q;
        if (i_valid) begin
            line0_d = i_data;
            line1_d = line0_q;
        end else begin
            line0_d = line0_q;
            line1_d = line1_q;
        end
    end

    // Delay line storage.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            line0_q <= 8'h00;
            line1_q <= 8'h00;
        end else begin
            line0_q <= line0_d;
            line1_q <= line1_d;
        end
    end

    assign o_leave = line1_q;
    assign o_match = i_valid && fas_pair_match(line0_q, i_data, B0, B1);

endmodule

// File: rtl/frame_aligner.sv
// frame_aligner: hunts the byte stream for the 2-byte FAS, confirms it over
// consecutive frames and then forwards whole frames with a strobe on byte 0.
// Nothing is forwarded out of frame, so downstream always starts at a frame
// boundary.
// Optional build macro FRAME_ALIGN_STATS_EN adds the o_lof_cnt port and a
// saturating loss-of-frame event counter.
module frame_aligner #(
    parameter int         ROW_NUM     = frame_pkg::ROW_NUM,
    parameter int         COL_NUM     = frame_pkg::COL_NUM,
    parameter logic [7:0] FAS_B0      = frame_pkg::FAS_B0,
    parameter logic [7:0] FAS_B1      = frame_pkg::FAS_B1,
    parameter int         PRESYNC_NUM = frame_pkg::PRESYNC_NUM,
    parameter int         LOSS_NUM    = frame_pkg::LOSS_NUM
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_ser_data,
    input  logic        i_ser_data_valid,
    output logic [7:0]  o_frame_data,
    output logic        o_frame_data_valid,
    output logic        o_frame_data_fas,
`ifdef FRAME_ALIGN_STATS_EN
    output logic        o_in_frame,
    output logic [15:0] o_lof_cnt
`else
    output logic        o_in_frame
`endif
);
    import frame_pkg::*;

    localparam int FRAME_BYTES = ROW_NUM * COL_NUM;
    localparam int POS_W       = $clog2(FRAME_BYTES);
    localparam int GOOD_W      = $clog2(PRESYNC_NUM + 1);
    localparam int MISS_W      = $clog2(LOSS_NUM + 1);

    localparam logic [POS_W-1:0]  POS_ZERO  = {POS_W{1'b0}};
    localparam logic [POS_W-1:0]  POS_ONE   = POS_W'(1);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(FRAME_BYTES - 1);
    localparam logic [GOOD_W-1:0] GOOD_ZERO = {GOOD_W{1'b0}};
    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_TGT  = GOOD_W'(PRESYNC_NUM);
    localparam logic [MISS_W-1:0] MISS_ZERO = {MISS_W{1'b0}};
    localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);
    localparam logic [MISS_W-1:0] MISS_TGT  = MISS_W'(LOSS_NUM);

    align_state_t      state_q,    state_d;
    logic [POS_W-1:0]  pos_q,      pos_d;
    logic [GOOD_W-1:0] good_q,     good_d;
    logic [MISS_W-1:0] miss_q,     miss_d;
    logic [7:0]        data_q,     data_d;
    logic              valid_q,    valid_d;
    logic              fas_q,      fas_d;
    logic              in_frame_q, in_frame_d;

    logic [POS_W-1:0]  cur_pos_s;
    logic              check_s;
    logic              match_s;
    logic              emit_s;
    logic [7:0]        leave_s;

    fas_detect #(
        .B0 (FAS_B0),
        .B1 (FAS_B1)
    ) u_fas_detect (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_data  (i_ser_data),
        .i_valid (i_ser_data_valid),
        .o_leave (leave_s),
        .o_match (match_s)
    );

    // Position of the incoming byte; the FAS check is decided on the pos-1 byte.
    always_comb begin
        cur_pos_s = POS_ZERO;
        if (pos_q == POS_LAST) begin
            cur_pos_s = POS_ZERO;
        end else begin
            cur_pos_s = pos_q + POS_ONE;
        end
        check_s = (cur_pos_s == POS_ONE);
    end

    // Alignment FSM next state plus position and good/miss counters.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        good_d  = good_q;
        miss_d  = miss_q;
        if (i_ser_data_valid) begin
            case (state_q)
                HUNT: begin
                    if (match_s) begin
                        pos_d = POS_ONE;
                        if (GOOD_TGT == GOOD_ONE) begin
                            state_d = SYNC;
                            good_d  = GOOD_ZERO;
                            miss_d  = MISS_ZERO;
                        end else begin
                            state_d = PRESYNC;
                            good_d  = GOOD_ONE;
                        end
                    end else begin
                        // A failed pair leaves the current byte as the next B0 candidate.
                        pos_d  = POS_ZERO;
                        good_d = GOOD_ZERO;
                    end
                end
                PRESYNC: begin
                    pos_d = cur_pos_s;
                    if (check_s) begin
                        if (match_s) begin
                            if ((good_q + GOOD_ONE) == GOOD_TGT) begin
                                state_d = SYNC;
                                good_d  = GOOD_ZERO;
                                miss_d  = MISS_ZERO;
                            end else begin
                                good_d = good_q + GOOD_ONE;
                            end
                        end else begin
                            state_d = HUNT;
                            pos_d   = POS_ZERO;
                            good_d  = GOOD_ZERO;
                        end
                    end else begin
                        good_d = good_q;
                    end
                end
                SYNC: begin
                    pos_d = cur_pos_s;
                    if (check_s) begin
                        if (match_s) begin
                            miss_d = MISS_ZERO;
                        end else if ((miss_q + MISS_ONE) == MISS_TGT) begin
                            state_d = HUNT;
                            pos_d   = POS_ZERO;
                            miss_d  = MISS_ZERO;
                        end else begin
                            miss_d = miss_q + MISS_ONE;
                        end
                    end else begin
                        miss_d = miss_q;
                    end
                end
                default: begin
                    state_d = HUNT;
                    pos_d   = POS_ZERO;
                    good_d  = GOOD_ZERO;
                    miss_d  = MISS_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
            pos_d   = pos_q;
        end
    end

    // Output gating: a byte leaving the delay line is forwarded only while the
    // FSM was already in SYNC, so the first byte after lock is the confirming
    // FAS_B0 and the byte after a loss is never the bad frame's FAS.
    always_comb begin
        emit_s     = i_ser_data_valid && (state_q == SYNC);
        valid_d    = emit_s;
        fas_d      = emit_s && (pos_q == POS_ONE);
        data_d     = data_q;
        in_frame_d = in_frame_q;
        if (emit_s) begin
            data_d = leave_s;
        end else begin
            data_d = data_q;
        end
        // In-frame rises with the first forwarded byte and falls with the last.
        if (i_ser_data_valid) begin
            in_frame_d = (state_q == SYNC) && (state_d == SYNC);
        end else begin
            in_frame_d = in_frame_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= HUNT;
            pos_q      <= POS_ZERO;
            good_q     <= GOOD_ZERO;
            miss_q     <= MISS_ZERO;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            fas_q      <= 1'b0;
            in_frame_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            good_q     <= good_d;
            miss_q     <= miss_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            fas_q      <= fas_d;
            in_frame_q <= in_frame_d;
        end
    end

    assign o_frame_data       = data_q;
    assign o_frame_data_valid = valid_q;
    assign o_frame_data_fas   = fas_q;
    assign o_in_frame         = in_frame_q;

`ifdef FRAME_ALIGN_STATS_EN
    logic        lof_s;
    logic [15:0] lof_cnt_q;
    logic [15:0] lof_cnt_d;

    // A loss-of-frame event is the bad check that exhausts the miss budget.
    always_comb begin
        lof_s = i_ser_data_valid && (state_q == SYNC) && check_s && !match_s &&
                ((miss_q + MISS_ONE) == MISS_TGT);
        if (lof_s && (lof_cnt_q != 16'hFFFF)) begin
            lof_cnt_d = lof_cnt_q + 16'd1;
        end else begin
            lof_cnt_d = lof_cnt_q;
        end
    end

    // Saturating loss-of-frame counter.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            lof_cnt_q <= 16'h0000;
        end else begin
            lof_cnt_q <= lof_cnt_d;
        end
    end

    assign o_lof_cnt = lof_cnt_q;
`endif

endmodule
